// File: rtl/uart_csr_bridge_pkg.sv
// Shared constants and FSM state encoding for the UART-to-CSR command bridge.
// Framing bytes, status codes and the CRC-8 polynomial are defined here once.
package uart_csr_pkg;

    localparam logic [7:0] SOF_REQ    = 8'hA5;
    localparam logic [7:0] SOF_RSP    = 8'h5A;
    localparam logic [7:0] CMD_WR     = 8'h01;
    localparam logic [7:0] CMD_RD     = 8'h02;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_CRC     = 8'h01;
    localparam logic [7:0] ST_ILLEGAL = 8'h02;

    localparam logic [7:0] CRC_POLY   = 8'h07;
    localparam int         RSP_LEN    = 7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA0,
        S_DATA1,
        S_DATA2,
        S_DATA3,
        S_CRC,
        S_EXEC,
        S_RESP
    } state_t;

endpackage

// File: rtl/uart_csr_bridge_crc8.sv
// Combinational CRC-8 step: folds one byte into a running CRC (MSB-first,
// no reflection). Polynomial comes from uart_csr_pkg.
module crc8_update
    import uart_csr_pkg::*;
(
    input  logic [7:0] i_crc,
    input  logic [7:0] i_data,
    output logic [7:0] o_crc
);

    always_comb begin
        o_crc = i_crc ^ i_data;
        for (int i = 0; i < 8; i++) begin
            if (o_crc[7]) begin
                o_crc = {o_crc[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                o_crc = {o_crc[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/uart_csr_bridge.sv
// UART command-frame parser that issues single-cycle CSR accesses and returns a
// 7-byte response frame. Optional inter-byte timeout: define UART_CSR_TIMEOUT_EN.
module uart_csr_bridge
    import uart_csr_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              crc_en,
    output logic              csr_wen,
    output logic              csr_ren,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [31:0]       csr_wdata,
    input  logic [31:0]       csr_rdata,
    output logic              rx_crc_error,
    output logic              rx_illegal_cmd,
    output logic              busy
);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_crc;
    logic [7:0]        w_req_crc_next;
    logic              r_is_wr;
    logic [ADDR_W-1:0] r_req_addr;
    logic [31:0]       r_req_wdata;
    logic [ADDR_W-1:0] r_csr_addr;
    logic [31:0]       r_csr_wdata;
    logic [31:0]       r_rdata;
    logic [7:0]        r_status;
    logic [2:0]        r_tx_idx;
    logic [7:0]        r_rsp_crc;
    logic [7:0]        w_rsp_crc_next;
    logic [7:0]        w_tx_byte;
    logic              r_crc_error;
    logic              r_illegal;
    logic              w_set_crc_err;
    logic              w_set_illegal;
    logic              w_timeout;
    logic              w_tx_fire;

    crc8_update u_req_crc (
        .i_crc  (r_crc),
        .i_data (rx_data),
        .o_crc  (w_req_crc_next)
    );

    crc8_update u_rsp_crc (
        .i_crc  (r_rsp_crc),
        .i_data (w_tx_byte),
        .o_crc  (w_rsp_crc_next)
    );

`ifdef UART_CSR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_parsing;

    assign w_parsing = (r_state inside {S_CMD, S_ADDR, S_DATA0, S_DATA1,
                                        S_DATA2, S_DATA3, S_CRC});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (!w_parsing || rx_valid) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive idle cycle inside a partial frame.
    assign w_timeout = w_parsing && !rx_valid &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_timeout        = 1'b0;
`endif

    assign w_tx_fire = tx_valid && tx_ready;

    always_comb begin
        w_next        = r_state;
        w_set_crc_err = 1'b0;
        w_set_illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_valid && rx_data == SOF_REQ) w_next = S_CMD;
            end
            S_CMD: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        w_next = S_ADDR;
                    end else begin
                        w_set_illegal = 1'b1;
                        w_next        = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    if (rx_data[1:0] != 2'b00) begin
                        w_set_illegal = 1'b1;
                        w_next        = S_RESP;
                    end else begin
                        w_next = r_is_wr ? S_DATA0 : S_CRC;
                    end
                end
            end
            S_DATA0: if (rx_valid) w_next = S_DATA1;
            S_DATA1: if (rx_valid) w_next = S_DATA2;
            S_DATA2: if (rx_valid) w_next = S_DATA3;
            S_DATA3: if (rx_valid) w_next = S_CRC;
            S_CRC: begin
                if (rx_valid) begin
                    if (crc_en && rx_data != r_crc) begin
                        w_set_crc_err = 1'b1;
                        w_next        = S_RESP;
                    end else begin
                        w_next = S_EXEC;
                    end
                end
            end
            S_EXEC: w_next = S_RESP;
            S_RESP: begin
                if (w_tx_fire && r_tx_idx == 3'(RSP_LEN - 1)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_set_illegal = 1'b1;
            w_next        = S_IDLE;
        end
    end

    always_comb begin
        w_tx_byte = 8'h00;
        if (r_state == S_RESP) begin
            case (r_tx_idx)
                3'd0:    w_tx_byte = SOF_RSP;
                3'd1:    w_tx_byte = r_status;
                3'd2:    w_tx_byte = r_rdata[7:0];
                3'd3:    w_tx_byte = r_rdata[15:8];
                3'd4:    w_tx_byte = r_rdata[23:16];
                3'd5:    w_tx_byte = r_rdata[31:24];
                3'd6:    w_tx_byte = r_rsp_crc;
                default: w_tx_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_crc       <= 8'h00;
            r_is_wr     <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_csr_addr  <= '0;
            r_csr_wdata <= '0;
            r_rdata     <= '0;
            r_status    <= 8'h00;
            r_tx_idx    <= '0;
            r_rsp_crc   <= 8'h00;
            r_crc_error <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_crc_error <= w_set_crc_err;
            r_illegal   <= w_set_illegal;
            case (r_state)
                S_IDLE: begin
                    if (rx_valid && rx_data == SOF_REQ) r_crc <= 8'h00;
                end
                S_CMD: begin
                    if (rx_valid) begin
                        r_crc   <= w_req_crc_next;
                        r_is_wr <= (rx_data == CMD_WR);
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        r_crc      <= w_req_crc_next;
                        r_req_addr <= ADDR_W'(rx_data);
                    end
                end
                S_DATA0: if (rx_valid) begin
                    r_crc              <= w_req_crc_next;
                    r_req_wdata[7:0]   <= rx_data;
                end
                S_DATA1: if (rx_valid) begin
                    r_crc              <= w_req_crc_next;
                    r_req_wdata[15:8]  <= rx_data;
                end
                S_DATA2: if (rx_valid) begin
                    r_crc              <= w_req_crc_next;
                    r_req_wdata[23:16] <= rx_data;
                end
                S_DATA3: if (rx_valid) begin
                    r_crc              <= w_req_crc_next;
                    r_req_wdata[31:24] <= rx_data;
                end
                // CSR-facing address/data only move when a checked request commits.
                S_CRC: begin
                    if (w_next == S_EXEC) begin
                        r_csr_addr <= r_req_addr;
                        if (r_is_wr) r_csr_wdata <= r_req_wdata;
                    end
                end
                S_EXEC: begin
                    r_status <= ST_OK;
                    r_rdata  <= r_is_wr ? 32'h0 : csr_rdata;
                end
                S_RESP: begin
                    if (w_tx_fire) begin
                        r_tx_idx <= r_tx_idx + 3'd1;
                        if (r_tx_idx >= 3'd1 && r_tx_idx <= 3'd5) r_rsp_crc <= w_rsp_crc_next;
                    end
                end
                default: ;
            endcase
            if (w_set_crc_err || (w_set_illegal && w_next == S_RESP)) begin
                r_status <= w_set_crc_err ? ST_CRC : ST_ILLEGAL;
                r_rdata  <= 32'h0;
            end
            if (r_state != S_RESP) begin
                r_tx_idx  <= '0;
                r_rsp_crc <= 8'h00;
            end
        end
    end

    assign tx_data        = w_tx_byte;
    assign tx_valid       = (r_state == S_RESP);
    assign csr_wen        = (r_state == S_EXEC) &&  r_is_wr;
    assign csr_ren        = (r_state == S_EXEC) && !r_is_wr;
    assign csr_addr       = r_csr_addr;
    assign csr_wdata      = r_csr_wdata;
    assign rx_crc_error   = r_crc_error;
    assign rx_illegal_cmd = r_illegal;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: doc/uart_csr_bridge.md
Name: uart_csr_bridge

Overview:
Host-side front end that feeds the CSR block.
- Parses framed command bytes from the UART receiver into single-cycle CSR write/read strobes.
- Checks a CRC-8 on every request frame and returns a fixed 7-byte response frame on the UART transmit stream.
- Reports CRC and illegal-command events as single-cycle pulses into the CSR sticky status bits.

Parameters:
ADDR_W, 8, CSR byte-address width; must match the CSR block.
TIMEOUT_CYC, 100000, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
tx_data  out  8  response byte
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  transmitter accepts a byte when tx_valid && tx_ready
crc_en  in  1  CRC check enable (from the CSR UART_crc_en field)
csr_wen  out  1  CSR write strobe, one cycle
csr_ren  out  1  CSR read strobe, one cycle
csr_addr  out  ADDR_W  CSR byte address
csr_wdata  out  32  CSR write data
csr_rdata  in  32  CSR read data, combinational from csr_addr
rx_crc_error  out  1  one-cycle pulse on CRC mismatch
rx_illegal_cmd  out  1  one-cycle pulse on bad command, unaligned address or timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, CRC accumulator 0x00.
- Request frame:
  - Write: SOF 0xA5, CMD 0x01, ADDR, D0..D3 (little-endian), CRC.
  - Read: SOF 0xA5, CMD 0x02, ADDR, CRC.
- CRC-8: polynomial 0x07, init 0x00, no reflection, no final XOR. Covers CMD through the last data byte; SOF and the CRC byte are excluded.
- States: IDLE -> CMD -> ADDR -> DATA0..DATA3 (write only) -> CRC -> EXEC -> RESP -> IDLE.
- IDLE: non-0xA5 bytes are dropped silently. 0xA5 clears the CRC accumulator and moves to CMD.
- CMD: a byte other than 0x01/0x02 pulses rx_illegal_cmd and moves to RESP with status 0x02.
- ADDR: if ADDR[1:0] != 0, pulse rx_illegal_cmd and move to RESP with status 0x02; no CSR access.
- CRC state: if crc_en=1 and the received byte differs from the accumulator, pulse rx_crc_error and move to RESP with status 0x01; no CSR access. If crc_en=0 the CRC byte is consumed and ignored.
- EXEC lasts exactly 1 cycle.
  - Write: csr_wen=1 with csr_addr/csr_wdata valid in that cycle.
  - Read: csr_ren=1 and csr_rdata is captured into the response register in the same cycle.
  - Status is set to 0x00.
- csr_addr and csr_wdata hold their last values outside EXEC. csr_wen and csr_ren are never both high.
- Response frame, 7 bytes in order: 0x5A, STATUS, R0..R3, CRC.
  - R = read data little-endian for an OK read; 0 for writes and errors.
  - CRC uses the same algorithm over STATUS..R3.
  - Each byte is held on tx_data with tx_valid=1 until tx_ready. Back-to-back bytes are allowed with no gap.
  - After byte 7 is accepted, return to IDLE.
- rx bytes arriving in EXEC/RESP are dropped; no flag is raised.
- Only one request is outstanding at a time; there is no queueing.
- Reset mid-frame or mid-response: immediate return to IDLE, tx_valid=0, no partial CSR access.

Optional Feature:
UART_CSR_TIMEOUT_EN
- Defined:
  - A counter runs in CMD..CRC and is cleared on each accepted rx byte.
  - When the count reaches TIMEOUT_CYC: pulse rx_illegal_cmd, return to IDLE, send no response.
  - The counter is $clog2(TIMEOUT_CYC+1) bits wide.
- Undefined: no counter; the parser waits indefinitely in a partial frame.

Decomposition:
- Package uart_csr_pkg:
  - Constants SOF_REQ=0xA5, SOF_RSP=0x5A, CMD_WR=0x01, CMD_RD=0x02.
  - Status codes ST_OK=0x00, ST_CRC=0x01, ST_ILLEGAL=0x02.
  - CRC_POLY=0x07, RSP_LEN=7.
  - State enum.
- Sub-module crc8_update: combinational next-CRC from (crc_in[7:0], byte[7:0]). Instantiated twice, once for request accumulation and once for response generation.

Test Plan:
- Write M: bytes A5 01 04 10 00 00 00 49, crc_en=1 -> one csr_wen cycle, addr 0x04, wdata 0x00000010; response 5A 00 00 00 00 00 00.
- Read M: bytes A5 02 04 36 with csr_rdata=0x10 -> one csr_ren cycle; response 5A 00 10 00 00 00 67.
- Bad CRC: A5 02 04 37, crc_en=1 -> 1-cycle rx_crc_error, no csr_ren, status 01. Same frame with crc_en=0 -> normal read.
- Illegal: CMD 0x07 -> rx_illegal_cmd pulse, status 02. ADDR 0x05 -> rx_illegal_cmd pulse, no CSR access.
- Backpressure: tx_ready low for 10 cycles per byte -> tx_data stable while stalled; exactly 7 bytes sent; rx bytes sent meanwhile are dropped. Leading junk 00 FF before A5 -> ignored.
- With UART_CSR_TIMEOUT_EN and TIMEOUT_CYC=50: send A5 01 then idle 50 cycles -> rx_illegal_cmd pulse, state IDLE, no tx; a following valid frame succeeds.
